// File: rtl/wb_regfile_pkg.sv
// Shared constants and helpers for the write-back stage register file.
package wb_regfile_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int SLOTS  = 12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [REG_W-1:0] REG_T0 = 5'd8;
  localparam logic [REG_W-1:0] REG_T1 = 5'd9;
  localparam logic [REG_W-1:0] REG_T2 = 5'd10;
  localparam logic [REG_W-1:0] REG_T3 = 5'd11;
  localparam logic [REG_W-1:0] REG_T4 = 5'd12;
  localparam logic [REG_W-1:0] REG_T5 = 5'd13;
  localparam logic [REG_W-1:0] REG_S0 = 5'd16;
  localparam logic [REG_W-1:0] REG_S1 = 5'd17;
  localparam logic [REG_W-1:0] REG_S2 = 5'd18;
  localparam logic [REG_W-1:0] REG_S3 = 5'd19;
  localparam logic [REG_W-1:0] REG_S4 = 5'd20;
  localparam logic [REG_W-1:0] REG_S5 = 5'd21;

  function automatic logic is_impl_reg(input logic [REG_W-1:0] r);
    return ((r >= REG_T0) && (r <= REG_T5)) || ((r >= REG_S0) && (r <= REG_S5));
  endfunction

  // t0..t5 occupy slots 0..5, s0..s5 occupy slots 6..11.
  function automatic logic [3:0] reg_slot(input logic [REG_W-1:0] r);
    logic [REG_W-1:0] off;
    if (r <= REG_T5) off = r - REG_T0;
    else             off = r - REG_S0 + 5'd6;
    return off[3:0];
  endfunction

endpackage

// File: rtl/wb_regfile_decode.sv
// Combinational write-back decode: picks destination register and data source.
module wb_decode
  import wb_regfile_pkg::*;
(
  input  logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] read_data,
  output logic              we,
  output logic [REG_W-1:0]  dest,
  output logic [DATA_W-1:0] data
);

  logic [5:0] opcode;
  assign opcode = instruction[31:26];

  always_comb begin
    we   = 1'b0;
    dest = '0;
    data = '0;
    unique case (opcode)
      OP_RTYPE: begin
        // An all-zero word is the NOP encoding, not an R-type to r0.
        if (instruction != '0) begin
          we   = 1'b1;
          dest = instruction[15:11];
          data = alu_result;
        end
      end
      OP_LW: begin
        we   = 1'b1;
        dest = instruction[20:16];
        data = read_data;
      end
      OP_ADDI: begin
        we   = 1'b1;
        dest = instruction[20:16];
        data = alu_result;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: latches the MEM-stage result, then commits it to t0..t5/s0..s5.
// Optional combinational forwarding of the pending write: define WB_FWD_EN.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_instruction,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [DATA_W-1:0] t0,
  output logic [DATA_W-1:0] t1,
  output logic [DATA_W-1:0] t2,
  output logic [DATA_W-1:0] t3,
  output logic [DATA_W-1:0] t4,
  output logic [DATA_W-1:0] t5,
  output logic [DATA_W-1:0] s0,
  output logic [DATA_W-1:0] s1,
  output logic [DATA_W-1:0] s2,
  output logic [DATA_W-1:0] s3,
  output logic [DATA_W-1:0] s4,
  output logic [DATA_W-1:0] s5,
  output logic [DATA_W-1:0] wb_instruction,
  output logic [15:0]       retire_count,
`ifdef WB_FWD_EN
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              bad_dest
);

  logic              dec_we;
  logic [REG_W-1:0]  dec_dest;
  logic [DATA_W-1:0] dec_data;

  logic              pend_we;
  logic [REG_W-1:0]  pend_reg;
  logic [DATA_W-1:0] pend_data;

  logic [DATA_W-1:0] rf [SLOTS];

  wb_decode u_decode (
    .instruction (mem_instruction),
    .alu_result  (mem_alu_result),
    .read_data   (mem_read_data),
    .we          (dec_we),
    .dest        (dec_dest),
    .data        (dec_data)
  );

  // Stage 1: latch the decoded write from MEM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_instruction <= '0;
      pend_we        <= 1'b0;
      pend_reg       <= '0;
      pend_data      <= '0;
    end else begin
      wb_instruction <= mem_instruction;
      pend_we        <= dec_we;
      pend_reg       <= dec_dest;
      pend_data      <= dec_data;
    end
  end

  // Stage 2: commit the pending write or flag an unimplemented destination.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SLOTS; i++) rf[i] <= '0;
      retire_count <= '0;
      bad_dest     <= 1'b0;
    end else if (pend_we && (pend_reg != '0)) begin
      if (is_impl_reg(pend_reg)) begin
        rf[reg_slot(pend_reg)] <= pend_data;
        retire_count           <= retire_count + 16'd1;
      end else begin
        bad_dest <= 1'b1;
      end
    end
  end

  assign t0 = rf[0];
  assign t1 = rf[1];
  assign t2 = rf[2];
  assign t3 = rf[3];
  assign t4 = rf[4];
  assign t5 = rf[5];
  assign s0 = rf[6];
  assign s1 = rf[7];
  assign s2 = rf[8];
  assign s3 = rf[9];
  assign s4 = rf[10];
  assign s5 = rf[11];

`ifdef WB_FWD_EN
  assign fwd_valid = pend_we && is_impl_reg(pend_reg);
  assign fwd_reg   = pend_reg;
  assign fwd_data  = pend_data;
`endif

endmodule
